// File: rtl/johnson_pkg.sv
// Shared helpers for the parametrised Johnson counter: phase width, pattern encoding, legality check.
// Optional phase-index output is enabled by defining JOHNSON_PHASE_OUT_EN.
package johnson_pkg;

    localparam int MAX_WIDTH = 64;

    function automatic int johnson_pw(input int width);
        return (width < 2) ? 1 : $clog2(2 * width);
    endfunction

    // Bit idx of the ring for a given phase: leading ones fill in, then leading zeros.
    function automatic logic pattern_bit(input int phase, input int width, input int idx);
        if (phase < width)
            return idx < phase;
        else
            return idx >= (phase - width);
    endfunction

    // Bit i of the result holds ring position q[i].
    function automatic logic [MAX_WIDTH-1:0] phase_to_pattern(input int phase, input int width);
        logic [MAX_WIDTH-1:0] pat;
        pat = '0;
        for (int i = 0; i < width; i++)
            pat[i] = pattern_bit(phase, width, i);
        return pat;
    endfunction

    // Legal rings have at most one place where neighbouring bits differ.
    function automatic logic is_valid_johnson(input logic [MAX_WIDTH-1:0] q, input int width);
        int changes;
        changes = 0;
        for (int i = 0; i < width - 1; i++)
            if (q[i] != q[i+1])
                changes++;
        return changes <= 1;
    endfunction

endpackage

// File: rtl/johnson_phase_decode.sv
// Turns a Johnson ring pattern into its binary phase index plus a legality bit.
module johnson_phase_decode
    import johnson_pkg::*;
#(
    parameter  int WIDTH = 4,
    localparam int PW    = johnson_pw(WIDTH)
) (
    input  logic [0:WIDTH-1] q,
    output logic [PW-1:0]    phase,
    output logic             valid
);

    logic [WIDTH-1:0] q_idx;

    always_comb begin
        q_idx = '0;
        for (int i = 0; i < WIDTH; i++)
            q_idx[i] = q[i];
    end

    // Ones-first rings count up from 0; zeros-first rings count down from 2*WIDTH.
    always_comb begin
        int ones;
        ones = 0;
        for (int i = 0; i < WIDTH; i++)
            if (q[i])
                ones++;
        valid = is_valid_johnson(MAX_WIDTH'(q_idx), WIDTH);
        if (!valid)
            phase = '0;
        else if (q[0] || ones == 0)
            phase = PW'(ones);
        else
            phase = PW'(2 * WIDTH - ones);
    end

endmodule

// File: rtl/johnson_counter_param.sv
// Parametrised bidirectional Johnson counter with load, terminal count and illegal-state recovery.
// Defining JOHNSON_PHASE_OUT_EN adds the decoded 'phase' output.
module johnson_counter_param
    import johnson_pkg::*;
#(
    parameter  int WIDTH       = 4,
    parameter  int RESET_PHASE = 0,
    localparam int PW          = johnson_pw(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [PW-1:0]    load_phase,
    output logic [0:WIDTH-1] q,
    output logic             tc,
    output logic             err
`ifdef JOHNSON_PHASE_OUT_EN
    ,
    output logic [PW-1:0]    phase
`endif
);

    logic [0:WIDTH-1] ring;
    logic [0:WIDTH-1] step_q;
    logic [0:WIDTH-1] load_pat;
    logic [0:WIDTH-1] reset_pat;
    logic             ring_valid;
    logic             load_ok;

    always_comb begin
        reset_pat = '0;
        load_pat  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            reset_pat[i] = pattern_bit(RESET_PHASE, WIDTH, i);
            load_pat[i]  = pattern_bit(int'(load_phase), WIDTH, i);
        end
        load_ok = int'(load_phase) < 2 * WIDTH;
    end

    // Twisted shift: the bit falling off one end re-enters inverted at the other.
    always_comb begin
        step_q = ring;
        if (dir) begin
            step_q[0] = ~ring[WIDTH-1];
            for (int i = 1; i < WIDTH; i++)
                step_q[i] = ring[i-1];
        end else begin
            step_q[WIDTH-1] = ~ring[0];
            for (int i = 0; i < WIDTH - 1; i++)
                step_q[i] = ring[i+1];
        end
    end

`ifdef JOHNSON_PHASE_OUT_EN
    johnson_phase_decode #(
        .WIDTH (WIDTH)
    ) u_decode (
        .q     (ring),
        .phase (phase),
        .valid (ring_valid)
    );
`else
    logic [WIDTH-1:0] ring_idx;

    always_comb begin
        ring_idx = '0;
        for (int i = 0; i < WIDTH; i++)
            ring_idx[i] = ring[i];
    end

    assign ring_valid = is_valid_johnson(MAX_WIDTH'(ring_idx), WIDTH);
`endif

    // Priority: reset, load, recovery from an illegal ring, step, hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            ring <= reset_pat;
            tc   <= 1'b0;
            err  <= 1'b0;
        end else begin
            tc <= 1'b0;
            if (load) begin
                if (load_ok)
                    ring <= load_pat;
                else
                    err <= 1'b1;
            end else if (!ring_valid) begin
                ring <= '0;
                err  <= 1'b1;
            end else if (en) begin
                ring <= step_q;
                tc   <= (step_q == '0);
            end
        end
    end

    assign q = ring;

endmodule
